// File: rtl/csr_access_unit_pkg.sv
// Shared types and encodings for the CSR access unit: funct3 codes, FSM states,
// CSR address/data types and the read-only address-space test.
package csr_access_unit_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  typedef logic [ADDR_W-1:0] csr_reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } csr_acc_state_t;

  // The top two address bits equal to 2'b11 mark the read-only CSR space.
  function automatic logic is_read_only(input logic [1:0] addr_top);
    return addr_top == 2'b11;
  endfunction

endpackage

// File: rtl/csr_alu.sv
// Combinational datapath for one Zicsr access: operand select, new CSR value,
// write-required flag and illegal-access detection.
module csr_alu
  import csr_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic [2:0]            op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [4:0]            rs1_field,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] old,
  output logic [DATA_WIDTH-1:0] new_value,
  output logic                  wr,
  output logic                  illegal
);

  logic [DATA_WIDTH-1:0] operand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default before the case so no path infers a latch.
    operand   = op[2] ? DATA_WIDTH'(rs1_field) : rs1_data;
    new_value = operand;
    wr        = 1'b0;
    case (op[1:0])
      CSRRW[1:0]: begin
        new_value = operand;
        wr        = 1'b1;
      end
      CSRRS[1:0]: begin
        new_value = old | operand;
        wr        = rs1_field != '0;
      end
      CSRRC[1:0]: begin
        new_value = old & ~operand;
        wr        = rs1_field != '0;
      end
      default: ;
    endcase
    illegal = (op[1:0] == 2'b00) || (wr && is_read_only(addr[ADDR_WIDTH-1 -: 2]));
  end

endmodule

// File: rtl/csr_access_unit.sv
// Initiator side of the CSR register-block port: runs one Zicsr read-modify-write
// per request and returns the old CSR value for rd writeback.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_req,
  output logic                  o_ready,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_csrAddr,
  input  logic [4:0]            i_rs1Field,
  input  logic [DATA_WIDTH-1:0] i_rs1Data,
  input  logic                  i_flush,
  output logic [ADDR_WIDTH-1:0] o_csrAddr,
  output logic                  o_csrWrEnable,
  output logic [DATA_WIDTH-1:0] o_csrWrData,
  input  logic [DATA_WIDTH-1:0] i_csrRdData,
  output logic                  o_done,
  output logic                  o_illegal,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  csr_acc_state_t        state, next_state;
  logic [2:0]            funct3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [4:0]            rs1_field_q;
  logic [DATA_WIDTH-1:0] rs1_data_q;
  logic [DATA_WIDTH-1:0] old_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0] new_value;
  logic                  wr;
  logic                  illegal;

  csr_alu #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_alu (
    .op       (funct3_q),
    .addr     (addr_q),
    .rs1_field(rs1_field_q),
    .rs1_data (rs1_data_q),
    .old      (old_q),
    .new_value(new_value),
    .wr       (wr),
    .illegal  (illegal)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      // NOTE: the capture registers are reset as well because o_csrAddr and o_rdData expose them directly.
      funct3_q    <= '0;
      addr_q      <= '0;
      rs1_field_q <= '0;
      rs1_data_q  <= '0;
      old_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here samples pre-edge values.
      state <= next_state;
      if (state == IDLE && i_req) begin
        funct3_q    <= i_funct3;
        addr_q      <= i_csrAddr;
        rs1_field_q <= i_rs1Field;
        rs1_data_q  <= i_rs1Data;
      end
      if (state == READ) old_q <= i_csrRdData;
      // The result register changes only on entry to DONE so it holds between requests.
      if (next_state == DONE) begin
        rd_data_q <= illegal ? '0 : ((state == READ) ? i_csrRdData : old_q);
      end
    end
  end

  always_comb begin
    next_state    = state;
    o_ready       = 1'b0;
    o_csrWrEnable = 1'b0;
    o_csrWrData   = '0;
    o_done        = 1'b0;
    o_illegal     = 1'b0;
    case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_req) next_state = READ;
      end
      READ: begin
        if (i_flush)      next_state = IDLE;
        else if (illegal) next_state = DONE;
        else if (wr)      next_state = WRITE;
        else              next_state = DONE;
      end
      WRITE: begin
        o_csrWrEnable = 1'b1;
        o_csrWrData   = new_value;
        next_state    = DONE;
      end
      DONE: begin
        o_done     = 1'b1;
        o_illegal  = illegal;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign o_csrAddr = addr_q;
  assign o_rdData  = rd_data_q;

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit: directed vector table, random requests
// against a reference model, and flush / reset / back-to-back sequences.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  logic          i_clock = 1'b0;
  logic          i_reset;
  logic          i_req;
  logic          o_ready;
  logic [2:0]    i_funct3;
  csr_reg_addr_t i_csrAddr;
  logic [4:0]    i_rs1Field;
  data_t         i_rs1Data;
  logic          i_flush;
  csr_reg_addr_t o_csrAddr;
  logic          o_csrWrEnable;
  data_t         o_csrWrData;
  data_t         i_csrRdData;
  logic          o_done;
  logic          o_illegal;
  data_t         o_rdData;

  always #5 i_clock = ~i_clock;

  csr_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(12)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_req        (i_req),
    .o_ready      (o_ready),
    .i_funct3     (i_funct3),
    .i_csrAddr    (i_csrAddr),
    .i_rs1Field   (i_rs1Field),
    .i_rs1Data    (i_rs1Data),
    .i_flush      (i_flush),
    .o_csrAddr    (o_csrAddr),
    .o_csrWrEnable(o_csrWrEnable),
    .o_csrWrData  (o_csrWrData),
    .i_csrRdData  (i_csrRdData),
    .o_done       (o_done),
    .o_illegal    (o_illegal),
    .o_rdData     (o_rdData)
  );

  // CSR block model: combinational read, write on the clock edge, preload port for the bench.
  data_t         csr_mem [4096];
  logic          pre_en = 1'b0;
  csr_reg_addr_t pre_addr = '0;
  data_t         pre_data = '0;

  assign i_csrRdData = csr_mem[o_csrAddr];

  always @(posedge i_clock) begin
    if (o_csrWrEnable)  csr_mem[o_csrAddr] <= o_csrWrData;
    else if (pre_en)    csr_mem[pre_addr]  <= pre_data;
  end

  int tests  = 0;
  int failed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic preload(input csr_reg_addr_t a, input data_t v);
    @(negedge i_clock);
    pre_en = 1'b1; pre_addr = a; pre_data = v;
    @(posedge i_clock); #1;
    pre_en = 1'b0;
  endtask

  typedef struct {
    int    wr_cnt;
    data_t wr_data;
    int    wr_cyc;
    int    done_cyc;
    data_t rd;
    bit    ill;
    bit    addr_bad;
    bit    wdata_bad;
  } obs_t;

  // Issue one request and observe the bus until o_done (cycle 1 = first cycle after accept).
  task automatic run_txn(input logic [2:0] f3, input csr_reg_addr_t a, input logic [4:0] rs1f,
                         input data_t rs1d, output obs_t o);
    int guard;
    o = '{0, '0, 0, 0, '0, 1'b0, 1'b0, 1'b0};
    guard = 0;
    @(negedge i_clock);
    while (!o_ready && guard < 10) begin
      @(negedge i_clock);
      guard++;
    end
    if (guard >= 10) check("ready_timeout", 32'(o_ready), 32'd1);
    i_req = 1'b1; i_funct3 = f3; i_csrAddr = a; i_rs1Field = rs1f; i_rs1Data = rs1d;
    @(posedge i_clock); #1;
    i_req = 1'b0;
    i_funct3 = 3'($urandom); i_csrAddr = 12'($urandom); i_rs1Field = 5'($urandom);
    i_rs1Data = $urandom;
    for (int c = 1; c <= 8 && o.done_cyc == 0; c++) begin
      if (c > 1) begin
        @(posedge i_clock); #1;
      end
      if (o_csrAddr !== a) o.addr_bad = 1'b1;
      if (o_csrWrEnable) begin
        o.wr_cnt++;
        o.wr_data = o_csrWrData;
        o.wr_cyc  = c;
      end else if (o_csrWrData !== '0) begin
        o.wdata_bad = 1'b1;
      end
      if (o_done) begin
        o.done_cyc = c;
        o.rd       = o_rdData;
        o.ill      = o_illegal;
      end
    end
    if (o.done_cyc == 0) check("done_timeout", 32'(o_done), 32'd1);
  endtask

  typedef struct {
    bit    wr;
    data_t after;
    bit    ill;
    data_t rd;
    int    done_cyc;
  } exp_t;

  // Reference model straight from the instruction rules.
  function automatic exp_t model(input logic [2:0] f3, input csr_reg_addr_t a,
                                 input logic [4:0] rs1f, input data_t rs1d, input data_t old);
    exp_t  e;
    data_t operand;
    bit    wants_write;
    operand     = f3[2] ? data_t'(rs1f) : rs1d;
    wants_write = (f3[1:0] == 2'b01) || (rs1f != 5'd0);
    e.ill       = (f3[1:0] == 2'b00) || (wants_write && a >= 12'hC00);
    e.wr        = wants_write && !e.ill;
    case (f3[1:0])
      2'b01:   e.after = operand;
      2'b10:   e.after = old | operand;
      default: e.after = old & ~operand;
    endcase
    if (!e.wr) e.after = old;
    e.rd       = e.ill ? '0 : old;
    e.done_cyc = e.wr ? 3 : 2;
    return e;
  endfunction

  typedef struct {
    logic [2:0]    f3;
    csr_reg_addr_t a;
    logic [4:0]    rs1f;
    data_t         rs1d;
    data_t         init;
    bit            exp_wr;
    data_t         exp_wdata;
    int            exp_done;
    data_t         exp_rd;
    bit            exp_ill;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  csr_reg_addr_t pool [8];

  initial begin
    obs_t  o;
    exp_t  e;
    data_t old;
    int    wr_seen, done_seen;

    i_reset = 1'b1; i_req = 1'b0; i_flush = 1'b0; i_funct3 = '0; i_csrAddr = '0;
    i_rs1Field = '0; i_rs1Data = '0;

    vecs[0]  = '{CSRRW,  12'h340, 5'd1,  32'hDEADBEEF, 32'h12345678, 1'b1, 32'hDEADBEEF, 3, 32'h12345678, 1'b0};
    vecs[1]  = '{CSRRS,  12'hC00, 5'd0,  32'hFFFFFFFF, 32'h00000042, 1'b0, 32'h0,        2, 32'h00000042, 1'b0};
    vecs[2]  = '{CSRRSI, 12'h300, 5'd5,  32'h0,        32'h0000000A, 1'b1, 32'h0000000F, 3, 32'h0000000A, 1'b0};
    vecs[3]  = '{CSRRC,  12'h300, 5'd3,  32'h0000000F, 32'h000000FF, 1'b1, 32'h000000F0, 3, 32'h000000FF, 1'b0};
    vecs[4]  = '{CSRRW,  12'hC01, 5'd1,  32'h00001234, 32'h00000077, 1'b0, 32'h0,        2, 32'h0,        1'b1};
    vecs[5]  = '{3'b100, 12'h300, 5'd2,  32'h00000005, 32'h00000099, 1'b0, 32'h0,        2, 32'h0,        1'b1};
    vecs[6]  = '{3'b000, 12'h340, 5'd0,  32'h0,        32'h00000005, 1'b0, 32'h0,        2, 32'h0,        1'b1};
    vecs[7]  = '{CSRRCI, 12'h305, 5'd0,  32'hFFFFFFFF, 32'h000000AA, 1'b0, 32'h0,        2, 32'h000000AA, 1'b0};
    vecs[8]  = '{CSRRWI, 12'hC02, 5'd0,  32'h0,        32'h00000003, 1'b0, 32'h0,        2, 32'h0,        1'b1};
    vecs[9]  = '{CSRRCI, 12'h341, 5'h1F, 32'h0,        32'hFFFFFFFF, 1'b1, 32'hFFFFFFE0, 3, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{CSRRS,  12'h7FF, 5'h10, 32'h80000001, 32'h00000100, 1'b1, 32'h80000101, 3, 32'h00000100, 1'b0};
    vecs[11] = '{CSRRW,  12'hBFF, 5'd0,  32'hCAFE0000, 32'h00000001, 1'b1, 32'hCAFE0000, 3, 32'h00000001, 1'b0};

    pool = '{12'h300, 12'h340, 12'h305, 12'h7C0, 12'h800, 12'hC00, 12'hC01, 12'hF11};

    // Reset state
    repeat (2) @(negedge i_clock);
    check("rst_ready",   32'(o_ready),       32'd1);
    check("rst_wren",    32'(o_csrWrEnable), 32'd0);
    check("rst_done",    32'(o_done),        32'd0);
    check("rst_illegal", 32'(o_illegal),     32'd0);
    check("rst_addr",    32'(o_csrAddr),     32'd0);
    check("rst_wdata",   o_csrWrData,        32'd0);
    check("rst_rddata",  o_rdData,           32'd0);
    i_reset = 1'b0;

    // Directed vector table
    for (int i = 0; i < NV; i++) begin
      preload(vecs[i].a, vecs[i].init);
      run_txn(vecs[i].f3, vecs[i].a, vecs[i].rs1f, vecs[i].rs1d, o);
      check($sformatf("vec%0d done_cycle", i), 32'(o.done_cyc), 32'(vecs[i].exp_done));
      check($sformatf("vec%0d rd_data", i),    o.rd,            vecs[i].exp_rd);
      check($sformatf("vec%0d illegal", i),    32'(o.ill),      32'(vecs[i].exp_ill));
      check($sformatf("vec%0d wr_pulses", i),  32'(o.wr_cnt),   vecs[i].exp_wr ? 32'd1 : 32'd0);
      check($sformatf("vec%0d addr_hold", i),  32'(o.addr_bad), 32'd0);
      check($sformatf("vec%0d wdata_idle", i), 32'(o.wdata_bad), 32'd0);
      if (vecs[i].exp_wr) begin
        check($sformatf("vec%0d wr_data", i),  o.wr_data,       vecs[i].exp_wdata);
        check($sformatf("vec%0d wr_cycle", i), 32'(o.wr_cyc),   32'd2);
      end
      check($sformatf("vec%0d csr_after", i), csr_mem[vecs[i].a],
            vecs[i].exp_wr ? vecs[i].exp_wdata : vecs[i].init);
      @(negedge i_clock); @(negedge i_clock);
      check($sformatf("vec%0d rd_hold", i), o_rdData, vecs[i].exp_rd);
    end

    // Random requests against the reference model
    for (int i = 0; i < 8; i++) preload(pool[i], $urandom);
    for (int n = 0; n < 150; n++) begin
      logic [2:0]    f3;
      csr_reg_addr_t a;
      logic [4:0]    rs1f;
      data_t         rs1d;
      f3   = 3'($urandom_range(0, 7));
      a    = pool[$urandom_range(0, 7)];
      rs1f = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      rs1d = $urandom;
      old  = csr_mem[a];
      e    = model(f3, a, rs1f, rs1d, old);
      run_txn(f3, a, rs1f, rs1d, o);
      check($sformatf("rnd%0d done_cycle", n), 32'(o.done_cyc), 32'(e.done_cyc));
      check($sformatf("rnd%0d rd_data", n),    o.rd,            e.rd);
      check($sformatf("rnd%0d illegal", n),    32'(o.ill),      32'(e.ill));
      check($sformatf("rnd%0d wr_pulses", n),  32'(o.wr_cnt),   e.wr ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d bus", n),        32'({o.addr_bad, o.wdata_bad}), 32'd0);
      check($sformatf("rnd%0d csr_after", n),  csr_mem[a],      e.after);
    end

    // Flush during READ: no write, no done, idle next cycle
    preload(12'h340, 32'h11110000);
    @(negedge i_clock);
    i_req = 1'b1; i_funct3 = CSRRW; i_csrAddr = 12'h340; i_rs1Field = 5'd1; i_rs1Data = 32'h5555;
    @(posedge i_clock); #1;
    i_req = 1'b0; i_flush = 1'b1;
    check("flush_read_addr", 32'(o_csrAddr), 32'h340);
    @(posedge i_clock); #1;
    i_flush = 1'b0;
    check("flush_ready", 32'(o_ready), 32'd1);
    wr_seen = 0; done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      if (o_csrWrEnable) wr_seen++;
      if (o_done) done_seen++;
      @(posedge i_clock); #1;
    end
    check("flush_no_write", 32'(wr_seen), 32'd0);
    check("flush_no_done",  32'(done_seen), 32'd0);
    check("flush_csr",      csr_mem[12'h340], 32'h11110000);

    // Flush during WRITE is ignored
    @(negedge i_clock);
    i_req = 1'b1; i_funct3 = CSRRS; i_csrAddr = 12'h340; i_rs1Field = 5'd2; i_rs1Data = 32'h0000000F;
    @(posedge i_clock); #1;
    i_req = 1'b0;
    @(posedge i_clock); #1;
    check("flushw_wren", 32'(o_csrWrEnable), 32'd1);
    i_flush = 1'b1;
    @(posedge i_clock); #1;
    i_flush = 1'b0;
    check("flushw_done", 32'(o_done), 32'd1);
    check("flushw_rd",   o_rdData, 32'h11110000);
    check("flushw_csr",  csr_mem[12'h340], 32'h1111000F);

    // Reset mid-WRITE: strobe drops immediately, nothing committed
    preload(12'h300, 32'h00000F0F);
    @(negedge i_clock);
    i_req = 1'b1; i_funct3 = CSRRW; i_csrAddr = 12'h300; i_rs1Field = 5'd1; i_rs1Data = 32'hABCD;
    @(posedge i_clock); #1;
    i_req = 1'b0;
    @(posedge i_clock); #1;
    check("rstw_wren_before", 32'(o_csrWrEnable), 32'd1);
    #2 i_reset = 1'b1;
    #1;
    check("rstw_wren_async", 32'(o_csrWrEnable), 32'd0);
    check("rstw_ready",      32'(o_ready),       32'd1);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    check("rstw_csr",    csr_mem[12'h300], 32'h00000F0F);
    check("rstw_done",   32'(o_done),      32'd0);
    check("rstw_rddata", o_rdData,         32'd0);

    // Back-to-back with request held high
    preload(12'hC00, 32'h00000042);
    @(negedge i_clock);
    i_req = 1'b1; i_funct3 = CSRRS; i_csrAddr = 12'hC00; i_rs1Field = 5'd0; i_rs1Data = 32'h0;
    @(posedge i_clock); #1;
    check("b2b_c1_busy", 32'(o_ready), 32'd0);
    @(posedge i_clock); #1;
    check("b2b_c2_done", 32'(o_done), 32'd1);
    @(posedge i_clock); #1;
    check("b2b_c3_ready", 32'(o_ready), 32'd1);
    @(posedge i_clock); #1;
    check("b2b_c4_accepted", 32'(o_ready), 32'd0);
    i_req = 1'b0;
    @(posedge i_clock); #1;
    check("b2b_c5_done", 32'(o_done),  32'd1);
    check("b2b_c5_rd",   o_rdData,     32'h00000042);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
